// File: rtl/io_ctrl_pkg.sv
// Shared types and default sizing for the confirm-button IO read controller.
package io_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    WAIT_PRESS = 2'd1,
    ACK        = 2'd2
  } state_e;

  localparam int DATA_W_DEF          = 16;
  localparam int DEBOUNCE_CYCLES_DEF = 20;

endpackage

// File: rtl/io_confirm_ctrl_btn_debounce.sv
// Confirm-button conditioning: 2-flop synchronizer, optional debounce, rising-edge pulse.
// Build option: IO_DEBOUNCE_EN enables the stable-cycle counter; otherwise btn_db is btn_sync registered once.
module btn_debounce
  import io_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_raw,
  output logic btn_db,
  output logic press_pulse
);

  logic sync1_q;
  logic sync2_q;
  logic db_q;
  logic db_d;
  logic db_dly_q;

  if (DEBOUNCE_CYCLES < 1) begin : g_bad_cfg
    $error("btn_debounce: DEBOUNCE_CYCLES must be at least 1");
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= btn_raw;
      sync2_q <= sync1_q;
    end
  end

`ifdef IO_DEBOUNCE_EN
  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Counter only climbs while sync disagrees with db; it is cleared on toggle, so it never wraps.
  always_comb begin
    cnt_d = '0;
    db_d  = db_q;
    if (sync2_q != db_q) begin
      if (cnt_q >= CNT_LAST) begin
        db_d = ~db_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`else
  always_comb begin
    db_d = sync2_q;
  end
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      db_q     <= 1'b0;
      db_dly_q <= 1'b0;
    end else begin
      db_q     <= db_d;
      db_dly_q <= db_q;
    end
  end

  assign btn_db      = db_q;
  assign press_pulse = db_q & ~db_dly_q;

endmodule

// File: rtl/io_confirm_ctrl.sv
// Stalls a CPU IO read until a fresh confirm-button press, then returns the latched switch value.
// Build option: IO_DEBOUNCE_EN (see btn_debounce) selects the debounced button path.
module io_confirm_ctrl
  import io_ctrl_pkg::*;
#(
  parameter int DATA_W          = DATA_W_DEF,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              confirm_btn,
  input  logic [DATA_W-1:0] sw_data,
  input  logic              rd_req,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              stall,
  output logic              wait_led
);

  logic btn_db;
  logic press_pulse;

  state_e            state_q;
  state_e            state_d;
  logic [DATA_W-1:0] rd_data_q;
  logic [DATA_W-1:0] rd_data_d;
  logic              rd_valid_q;
  logic              rd_valid_d;
  logic              wait_led_q;
  logic              wait_led_d;

  btn_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_btn_debounce (
    .clk        (clk),
    .rst        (rst),
    .btn_raw    (confirm_btn),
    .btn_db     (btn_db),
    .press_pulse(press_pulse)
  );

  // Presses are only consumed in WAIT_PRESS, so a pulse seen in IDLE is dropped.
  always_comb begin
    state_d    = state_q;
    rd_data_d  = rd_data_q;
    rd_valid_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (rd_req) begin
          state_d = WAIT_PRESS;
        end
      end
      WAIT_PRESS: begin
        if (!rd_req) begin
          state_d = IDLE;
        end else if (press_pulse) begin
          rd_data_d  = sw_data;
          rd_valid_d = 1'b1;
          state_d    = ACK;
        end
      end
      ACK: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    wait_led_d = (state_d == WAIT_PRESS);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      wait_led_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
      wait_led_q <= wait_led_d;
    end
  end

  // Combinational so the CPU freezes in the very cycle its request rises.
  assign stall    = (state_q == WAIT_PRESS) | ((state_q == IDLE) & rd_req);
  assign rd_data  = rd_data_q;
  assign rd_valid = rd_valid_q;
  assign wait_led = wait_led_q;

endmodule
